// File: rtl/reg_bus_pkg.sv
// Shared widths, the arbiter FSM state encoding and fixed register indices.
package reg_bus_pkg;

  localparam int REG_INDEX_W = 7;
  localparam int REG_DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  localparam logic [REG_INDEX_W-1:0] REG_CONSOLE = 7'd0;

endpackage

// File: rtl/reg_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module sat_counter #(
  parameter int          WIDTH = 16,
  parameter int unsigned MAX   = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master register bus arbiter: the core always wins, the host waits in PEND.
// Optional statistics counters are built when REG_ARB_STATS_EN is defined.
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [REG_INDEX_W-1:0] core_index,
  input  logic                   core_read,
  input  logic                   core_write,
  input  logic [REG_DATA_W-1:0]  core_write_value,
  output logic [REG_DATA_W-1:0]  core_read_value,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [REG_INDEX_W-1:0] host_index,
  input  logic [REG_DATA_W-1:0]  host_wdata,
  output logic                   host_ack,
  output logic [REG_DATA_W-1:0]  host_rdata,
  output logic                   host_starved,
  output logic [REG_INDEX_W-1:0] register_index,
  output logic                   register_read,
  output logic                   register_write,
  output logic [REG_DATA_W-1:0]  register_write_value,
  input  logic [REG_DATA_W-1:0]  register_read_value,
`ifdef REG_ARB_STATS_EN
  output logic [15:0]            stat_core_cnt,
  output logic [15:0]            stat_host_cnt,
  output logic [15:0]            stat_conflict_cnt,
`endif
  output arb_state_t             dbg_state
);

  // Host handshake: host_req is a level held with stable args until host_ack;
  // host_ack is a one-cycle pulse and the host drops req the cycle after it.
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  arb_state_t state_q, state_d;
  logic                   core_active;
  logic                   latch_en, issue, wait_clr, wait_inc, starve_hit;
  logic [15:0]            wait_cnt;
  logic                   we_l_q;
  logic [REG_INDEX_W-1:0] idx_l_q;
  logic [REG_DATA_W-1:0]  wdata_l_q;
  logic [REG_DATA_W-1:0]  core_rdata_q, host_rdata_q;
  logic                   starved_q;

  assign core_active = core_read | core_write;

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    issue    = 1'b0;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    host_ack = 1'b0;
    case (state_q)
      IDLE: if (host_req) begin
        latch_en = 1'b1;
        wait_clr = 1'b1;
        state_d  = PEND;
      end
      PEND: if (!core_active) begin
        issue   = 1'b1;
        state_d = ACK;
      end else begin
        wait_inc = 1'b1;
      end
      ACK: begin
        host_ack = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    register_index       = '0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    register_write_value = '0;
    if (core_active) begin
      register_index       = core_index;
      register_read        = core_read;
      register_write       = core_write;
      register_write_value = core_write_value;
    end else if (state_q == PEND) begin
      register_index       = idx_l_q;
      register_read        = ~we_l_q;
      register_write       = we_l_q;
      register_write_value = wdata_l_q;
    end
  end

  // The counter only ever reaches MAX_WAIT through this step, so it marks starvation.
  assign starve_hit = wait_inc && (wait_cnt == WAIT_LAST);

  sat_counter #(.WIDTH(16), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (wait_clr),
    .inc_i (wait_inc),
    .cnt_o (wait_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      we_l_q       <= 1'b0;
      idx_l_q      <= '0;
      wdata_l_q    <= '0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
      starved_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        we_l_q    <= host_we;
        idx_l_q   <= host_index;
        wdata_l_q <= host_wdata;
      end
      if (core_read) core_rdata_q <= register_read_value;
      if (issue && !we_l_q) host_rdata_q <= register_read_value;
      if (starve_hit) starved_q <= 1'b1;
    end
  end

  assign core_read_value = core_rdata_q;
  assign host_rdata      = host_rdata_q;
  assign host_starved    = starved_q;
  assign dbg_state       = state_q;

`ifdef REG_ARB_STATS_EN
  sat_counter #(.WIDTH(16), .MAX(65535)) u_stat_core (
    .clk(clk), .rst_n(reset_n), .clr_i(1'b0), .inc_i(core_active), .cnt_o(stat_core_cnt)
  );
  sat_counter #(.WIDTH(16), .MAX(65535)) u_stat_host (
    .clk(clk), .rst_n(reset_n), .clr_i(1'b0), .inc_i(host_ack), .cnt_o(stat_host_cnt)
  );
  sat_counter #(.WIDTH(16), .MAX(65535)) u_stat_conflict (
    .clk(clk), .rst_n(reset_n), .clr_i(1'b0), .inc_i(wait_inc), .cnt_o(stat_conflict_cnt)
  );
`else
  // Statistics counters are compiled out in this build.
`endif

endmodule
